// File: rtl/mem_store_buf_if.sv
// Store-buffer bus: EX/MEM store requests, MEM-stage load check, and the RAM write port.
// Port names match the original flat module for drop-in compatibility.
interface mem_store_buf_if #(
    parameter int AW = 32
);
    logic          st_valid_i;
    logic          st_ready_o;
    logic [2:0]    st_funct3_i;
    logic [AW-1:0] st_addr_i;
    logic [31:0]   st_data_i;
    logic          st_exc_o;
    logic [AW-1:0] ld_chk_addr_i;
    logic          ld_chk_en_i;
    logic          ld_hazard_o;
    logic          ram_req_o;
    logic          ram_gnt_i;
    logic [AW-1:0] ram_addr_o;
    logic [31:0]   ram_wdata_o;
    logic [3:0]    ram_wmask_o;
    logic          empty_o;

    modport slave (
        input  st_valid_i, st_funct3_i, st_addr_i, st_data_i,
        input  ld_chk_addr_i, ld_chk_en_i, ram_gnt_i,
        output st_ready_o, st_exc_o, ld_hazard_o,
        output ram_req_o, ram_addr_o, ram_wdata_o, ram_wmask_o, empty_o
    );

    modport master (
        output st_valid_i, st_funct3_i, st_addr_i, st_data_i,
        output ld_chk_addr_i, ld_chk_en_i, ram_gnt_i,
        input  st_ready_o, st_exc_o, ld_hazard_o,
        input  ram_req_o, ram_addr_o, ram_wdata_o, ram_wmask_o, empty_o
    );
endinterface

// File: rtl/mem_store_buf.sv
// Store buffer: formats SB/SH/SW into lane-replicated word writes, queues them in a
// DEPTH-entry FIFO drained over req/gnt, and flags loads that hit a pending store.
module mem_store_buf #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    mem_store_buf_if.slave bus
);
    localparam int PW = $clog2(DEPTH);

    logic [AW-3:0] addr_mem [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic [3:0]    mask_mem [DEPTH];

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;

    logic [AW-3:0] last_addr;
    logic [31:0]   last_wdata;
    logic [3:0]    last_mask;
    logic          exc_q;

    logic [1:0]    lane;
    logic [31:0]   fmt_wdata;
    logic [3:0]    fmt_mask;
    logic          legal;
    logic          aligned;
    logic          full;
    logic          ready;
    logic          accept;
    logic          enq;
    logic          reject;
    logic          req;
    logic          pop;
    logic          hazard;
    logic [PW-1:0] slot_off;

    always_comb begin
        lane      = bus.st_addr_i[1:0];
        fmt_wdata = '0;
        fmt_mask  = '0;
        legal     = 1'b1;
        aligned   = 1'b1;
        case (bus.st_funct3_i)
            3'b000: begin
                fmt_wdata = {4{bus.st_data_i[7:0]}};
                fmt_mask  = 4'b0001 << lane;
            end
            3'b001: begin
                fmt_wdata = {2{bus.st_data_i[15:0]}};
                fmt_mask  = lane[1] ? 4'b1100 : 4'b0011;
                aligned   = !lane[0];
            end
            3'b010: begin
                fmt_wdata = bus.st_data_i;
                fmt_mask  = 4'b1111;
                aligned   = (lane == 2'b00);
            end
            default: legal = 1'b0;
        endcase
    end

    // Ready is based on registered occupancy only; a same-cycle pop does not free a slot.
    assign full   = (count == (PW+1)'(DEPTH));
    assign ready  = !full;
    assign accept = bus.st_valid_i && ready;
    assign enq    = accept && legal && aligned;
    assign reject = accept && !(legal && aligned);
    assign req    = (count != '0);
    assign pop    = req && bus.ram_gnt_i;

    always_ff @(posedge clk) begin
        if (enq) begin
            addr_mem[wr_ptr] <= bus.st_addr_i[AW-1:2];
            data_mem[wr_ptr] <= fmt_wdata;
            mask_mem[wr_ptr] <= fmt_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            exc_q      <= 1'b0;
            last_addr  <= '0;
            last_wdata <= '0;
            last_mask  <= '0;
        end else begin
            exc_q <= reject;
            if (enq) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                last_addr  <= addr_mem[rd_ptr];
                last_wdata <= data_mem[rd_ptr];
                last_mask  <= mask_mem[rd_ptr];
                rd_ptr     <= rd_ptr + 1'b1;
            end
            case ({enq, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // A slot is live when its distance from the head is below the occupancy.
    always_comb begin
        hazard   = 1'b0;
        slot_off = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            slot_off = PW'(i) - rd_ptr;
            if (({1'b0, slot_off} < count) &&
                (addr_mem[i] == bus.ld_chk_addr_i[AW-1:2])) begin
                hazard = 1'b1;
            end
        end
    end

    logic unused_ld_lsbs;
    assign unused_ld_lsbs = ^bus.ld_chk_addr_i[1:0];

    // With the queue empty the RAM bus holds the last popped entry.
    assign bus.ram_addr_o  = {(req ? addr_mem[rd_ptr] : last_addr), 2'b00};
    assign bus.ram_wdata_o = req ? data_mem[rd_ptr] : last_wdata;
    assign bus.ram_wmask_o = req ? mask_mem[rd_ptr] : last_mask;
    assign bus.ram_req_o   = req;
    assign bus.st_ready_o  = ready;
    assign bus.st_exc_o    = exc_q;
    assign bus.ld_hazard_o = bus.ld_chk_en_i && hazard;
    assign bus.empty_o     = (count == '0);
endmodule

// File: tb/tb_mem_store_buf.sv
// Directed bench for mem_store_buf: a queue-based model checked every cycle,
// plus literal expectations for the hand-worked scenarios.
module tb_mem_store_buf;
    localparam int DEPTH = 4;
    localparam int AW    = 32;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_store_buf_if #(.AW(AW)) bus ();
    mem_store_buf #(.DEPTH(DEPTH), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;

    ent_t mq[$];
    ent_t m_last;
    logic m_exc = 1'b0;
    logic armed = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Model: updated on every rising edge from the inputs presented that cycle.
    initial begin : model
        ent_t        e;
        logic        ok;
        logic        pop;
        logic [1:0]  a;
        logic [31:0] d;
        m_last = '{addr: 32'h0, wdata: 32'h0, mask: 4'h0};
        forever begin
            @(posedge clk);
            if (rst) begin
                mq.delete();
                m_last = '{addr: 32'h0, wdata: 32'h0, mask: 4'h0};
                m_exc  = 1'b0;
                armed  = 1'b1;
            end else begin
                pop = (mq.size() != 0) && bus.ram_gnt_i;
                ok  = 1'b0;
                e   = '{addr: 32'h0, wdata: 32'h0, mask: 4'h0};
                if (bus.st_valid_i && mq.size() < DEPTH) begin
                    a = bus.st_addr_i[1:0];
                    d = bus.st_data_i;
                    e.addr = bus.st_addr_i & 32'hFFFF_FFFC;
                    case (bus.st_funct3_i)
                        3'd0: begin
                            e.wdata = (d & 32'hFF) * 32'h0101_0101;
                            e.mask  = 4'(1 << a);
                            ok      = 1'b1;
                        end
                        3'd1: begin
                            e.wdata = (d & 32'hFFFF) * 32'h0001_0001;
                            e.mask  = (a >= 2) ? 4'hC : 4'h3;
                            ok      = (a % 2 == 0);
                        end
                        3'd2: begin
                            e.wdata = d;
                            e.mask  = 4'hF;
                            ok      = (a == 0);
                        end
                        default: ok = 1'b0;
                    endcase
                    m_exc = !ok;
                end else begin
                    m_exc = 1'b0;
                end
                if (pop) m_last = mq.pop_front();
                if (ok) mq.push_back(e);
            end
        end
    end

    initial begin : compare
        ent_t head;
        logic hz;
        forever begin
            @(negedge clk);
            if (armed) begin
                head = (mq.size() != 0) ? mq[0] : m_last;
                hz = 1'b0;
                foreach (mq[i]) begin
                    if ((mq[i].addr >> 2) == (bus.ld_chk_addr_i >> 2)) hz = 1'b1;
                end
                hz = hz && bus.ld_chk_en_i;
                chk("ready",  32'(bus.st_ready_o),  32'(mq.size() < DEPTH));
                chk("exc",    32'(bus.st_exc_o),    32'(m_exc));
                chk("req",    32'(bus.ram_req_o),   32'(mq.size() != 0));
                chk("empty",  32'(bus.empty_o),     32'(mq.size() == 0));
                chk("hazard", 32'(bus.ld_hazard_o), 32'(hz));
                chk("addr",   bus.ram_addr_o,       head.addr);
                chk("wdata",  bus.ram_wdata_o,      head.wdata);
                chk("wmask",  32'(bus.ram_wmask_o), 32'(head.mask));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data);
        bus.st_valid_i  = 1'b1;
        bus.st_funct3_i = f3;
        bus.st_addr_i   = addr;
        bus.st_data_i   = data;
        cyc();
        bus.st_valid_i  = 1'b0;
    endtask

    initial begin : stim
        bus.st_valid_i    = 1'b0;
        bus.st_funct3_i   = 3'd0;
        bus.st_addr_i     = '0;
        bus.st_data_i     = '0;
        bus.ld_chk_addr_i = '0;
        bus.ld_chk_en_i   = 1'b0;
        bus.ram_gnt_i     = 1'b0;
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        chk("rst_req",   32'(bus.ram_req_o),  32'd0);
        chk("rst_empty", 32'(bus.empty_o),    32'd1);
        chk("rst_ready", 32'(bus.st_ready_o), 32'd1);
        chk("rst_addr",  bus.ram_addr_o,      32'h0);

        // 1: SB at byte 3, popped immediately; load check on the same word
        bus.ram_gnt_i     = 1'b1;
        bus.ld_chk_en_i   = 1'b1;
        bus.ld_chk_addr_i = 32'h1001;
        store(3'b000, 32'h1003, 32'h0000_00A5);
        chk("t1_req",   32'(bus.ram_req_o),   32'd1);
        chk("t1_addr",  bus.ram_addr_o,       32'h1000);
        chk("t1_wdata", bus.ram_wdata_o,      32'hA5A5_A5A5);
        chk("t1_mask",  32'(bus.ram_wmask_o), 32'h8);
        chk("t1_hz",    32'(bus.ld_hazard_o), 32'd1);
        cyc();
        chk("t1_empty", 32'(bus.empty_o),     32'd1);
        chk("t1_hold",  bus.ram_addr_o,       32'h1000);
        bus.ld_chk_en_i = 1'b0;

        // 2: SH upper half, then misaligned SH / illegal funct3 / misaligned SW
        bus.ram_gnt_i = 1'b0;
        store(3'b001, 32'h2002, 32'h0000_1234);
        chk("t2_wdata", bus.ram_wdata_o,      32'h1234_1234);
        chk("t2_mask",  32'(bus.ram_wmask_o), 32'hC);
        store(3'b001, 32'h2001, 32'h0000_5678);
        chk("t2_exc",   32'(bus.st_exc_o),    32'd1);
        chk("t2_head",  bus.ram_addr_o,       32'h2000);
        cyc();
        chk("t2_exc0",  32'(bus.st_exc_o),    32'd0);
        store(3'b011, 32'h3000, 32'h1);
        chk("t2_ill",   32'(bus.st_exc_o),    32'd1);
        store(3'b010, 32'h3002, 32'h2);
        chk("t2_swmis", 32'(bus.st_exc_o),    32'd1);
        bus.ram_gnt_i = 1'b1;
        cyc();
        bus.ram_gnt_i = 1'b0;
        cyc();

        // 3: fill with four SWs, then drain in order
        for (int k = 0; k < 4; k++) store(3'b010, 32'(4 * k), 32'hC0DE_0000 + 32'(k));
        chk("t3_full", 32'(bus.st_ready_o), 32'd0);
        bus.ram_gnt_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("t3_addr",  bus.ram_addr_o,  32'(4 * k));
            chk("t3_wdata", bus.ram_wdata_o, 32'hC0DE_0000 + 32'(k));
            cyc();
        end
        chk("t3_empty", 32'(bus.empty_o), 32'd1);

        // 4: full FIFO, store offered alongside a pop is not accepted
        bus.ram_gnt_i = 1'b0;
        for (int k = 0; k < 4; k++) store(3'b010, 32'h10 + 32'(4 * k), 32'h5500 + 32'(k));
        bus.ram_gnt_i = 1'b1;
        store(3'b010, 32'h20, 32'hBAD0_BAD0);
        bus.ram_gnt_i = 1'b0;
        chk("t4_ready", 32'(bus.st_ready_o), 32'd1);
        chk("t4_exc",   32'(bus.st_exc_o),   32'd0);
        bus.ram_gnt_i = 1'b1;
        for (int k = 1; k < 4; k++) begin
            chk("t4_addr", bus.ram_addr_o, 32'h10 + 32'(4 * k));
            cyc();
        end
        chk("t4_empty", 32'(bus.empty_o), 32'd1);

        // 5: word-granular load hazard
        bus.ram_gnt_i = 1'b0;
        store(3'b010, 32'h40, 32'hDEAD_BEEF);
        bus.ld_chk_en_i   = 1'b1;
        bus.ld_chk_addr_i = 32'h42;
        #1 chk("t5_hit",  32'(bus.ld_hazard_o), 32'd1);
        bus.ld_chk_addr_i = 32'h44;
        #1 chk("t5_miss", 32'(bus.ld_hazard_o), 32'd0);
        bus.ld_chk_addr_i = 32'h42;
        bus.ld_chk_en_i   = 1'b0;
        #1 chk("t5_dis",  32'(bus.ld_hazard_o), 32'd0);
        bus.ld_chk_en_i   = 1'b1;
        cyc();

        // 6: reset with two entries pending discards them
        store(3'b000, 32'h48, 32'h0000_0007);
        chk("t6_req", 32'(bus.ram_req_o), 32'd1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("t6_req0",  32'(bus.ram_req_o),   32'd0);
        chk("t6_empty", 32'(bus.empty_o),     32'd1);
        chk("t6_ready", 32'(bus.st_ready_o),  32'd1);
        chk("t6_wdata", bus.ram_wdata_o,      32'h0);
        chk("t6_hz",    32'(bus.ld_hazard_o), 32'd0);
        bus.ram_gnt_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("t6_noreq", 32'(bus.ram_req_o), 32'd0);
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
